// File: rtl/uart_ctrl_pkg.sv
// Purpose: shared types and helpers for the UART controller blocks.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: FSM state enum, byte width, and index-width helper (clog2, min 1).
package uart_ctrl_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_arb_state_t;

  // Width of an index into n requesters; a single requester still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Purpose: combinational round-robin picker over a request vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is used.
// Ports: req_valid - pending requests; last - previous winner (scan starts at last+1);
//        winner - first valid index after last, mod NUM_REQ; any_valid - OR of req_valid.
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      winner,
  output logic               any_valid
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    winner    = '0;
    found     = 1'b0;
    idx       = '0;
    any_valid = |req_valid;
    // Walk last+1, last+2, ... wrapping; the last step revisits last itself.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IW'((int'(last) + off) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one UART transmitter among NUM_REQ byte sources.
// Latency: grant decided in cycle T, TX_Start and req_ready pulse at T+1.
// Backpressure: requesters hold req_valid until req_ready; no grant while TX_BUSY is high.
// Ports: clk_100MHz/reset (sync, active-high); req_valid/req_data/req_ready requester side;
//        TX_BUSY/TX_Start/TX_DATA transmitter side; grant_id last winner; arb_busy state!=IDLE;
//        timeout_err pulses when TX_BUSY never rose within BUSY_TIMEOUT cycles.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int BUSY_TIMEOUT = 16,
  localparam int IW           = idx_width(NUM_REQ)
) (
  input  logic                           clk_100MHz,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           TX_BUSY,
  output logic                           TX_Start,
  output logic [UART_BYTE_W-1:0]         TX_DATA,
  output logic [IW-1:0]                  grant_id,
  output logic                           arb_busy,
  output logic                           timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  tx_arb_state_t        state;
  logic [TW-1:0]        timer;
  // Round-robin pointer; differs from grant_id only in its reset value,
  // which makes requester 0 the first winner after reset.
  logic [IW-1:0]        last;
  logic [IW-1:0]        winner;
  logic                 any_valid;
  logic [UART_BYTE_W-1:0] pick_data;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .last      (last),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IW'(i)) begin
        pick_data = req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      last        <= IW'(NUM_REQ - 1);
      grant_id    <= '0;
      TX_Start    <= 1'b0;
      TX_DATA     <= '0;
      req_ready   <= '0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Pulsed outputs default low every cycle.
      TX_Start    <= 1'b0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!TX_BUSY && any_valid) begin
            TX_DATA   <= pick_data;
            grant_id  <= winner;
            last      <= winner;
            // Start and ready are registered here so they are visible
            // for exactly the one cycle spent in START.
            TX_Start  <= 1'b1;
            req_ready <= NUM_REQ'(1) << winner;
            arb_busy  <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (TX_BUSY) begin
            state <= WAIT_DONE;
          end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
            // Byte counts as consumed; no retry.
            timeout_err <= 1'b1;
            arb_busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: self-checking bench for uart_tx_arbiter (2 requesters, timeout 16).
// Latency: n/a.
// Backpressure: n/a.
// Ports: none; drives the DUT with directed steps followed by a randomized run.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [0:0]     grant_id;
  logic           arb_busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .TX_BUSY     (tx_busy),
    .TX_Start    (tx_start),
    .TX_DATA     (tx_data),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transmitter model: mode 0 = tx_busy driven directly by the test,
  // mode 1 = busy rises the cycle after TX_Start and stays high cur_len cycles.
  int busy_mode = 0;
  int busy_rand = 0;
  int busy_len  = 10;
  int rem       = 0;
  int cur_len   = 0;

  // Requester model: 0 = one-shot, 1 = re-present next byte (+1) the next cycle,
  // 2 = re-present a random byte after a random gap.
  int refill = 0;
  int gap [N];

  logic [N-1:0]   v_prev;
  logic [8*N-1:0] d_prev;
  logic           b_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance past the edge, remember what the DUT just sampled,
  // then update the transmitter and requester models.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    v_prev = req_valid;
    d_prev = req_data;
    b_prev = tx_busy;
    if (busy_mode == 1) begin
      if (rem > 0) begin
        tx_busy = 1'b1;
        rem--;
      end else begin
        tx_busy = 1'b0;
      end
      if (tx_start === 1'b1) begin
        if (busy_rand != 0)
          cur_len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
        else
          cur_len = busy_len;
        rem = cur_len;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (gap[i] > 0) begin
        gap[i]--;
        if (gap[i] == 0) begin
          req_valid[i] = 1'b1;
          if (refill == 1) req_data[8*i +: 8] = req_data[8*i +: 8] + 8'd1;
          else             req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] === 1'b1) begin
        req_valid[i] = 1'b0;
        if (refill == 1)      gap[i] = 1;
        else if (refill == 2) gap[i] = int'($urandom_range(1, 4));
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    req_valid = '0;
    refill    = 0;
    rem       = 0;
    for (int i = 0; i < N; i++) gap[i] = 0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    int s;
    int n;
    int found;
    int idle_from;
    int exp_to;
    int exp_last;
    int w;
    logic       exp_start;
    logic [7:0] exp_data;
    logic [0:0] exp_grant;
    logic [N-1:0] exp_ready;

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    for (int i = 0; i < N; i++) gap[i] = 0;

    // Reset state
    do_reset(3);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_arb", 32'(arb_busy), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    // Single request; busy high S+1..S+10, low from S+11
    busy_mode = 1; busy_rand = 0; busy_len = 10;
    req_valid = 2'b01; req_data = 16'h0041;
    step();
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data", 32'(tx_data), 32'h41);
    chk("t1_ready", 32'(req_ready), 32'b01);
    chk("t1_grant", 32'(grant_id), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_no_start", 32'(tx_start), 32'd0);
      if (k == 11) chk("t1_arb_hold", 32'(arb_busy), 32'd1);
      if (k == 12) chk("t1_arb_fall", 32'(arb_busy), 32'd0);
    end

    // Simultaneous requests after reset: 0x11 then 0x22, 2 cycles after busy low
    do_reset(2);
    req_valid = 2'b11; req_data = 16'h2211;
    step();
    chk("t2_first_data", 32'(tx_data), 32'h11);
    chk("t2_first_grant", 32'(grant_id), 32'd0);
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("t2_second_start", 32'(tx_start), 32'(k == 13));
    end
    chk("t2_second_data", 32'(tx_data), 32'h22);
    chk("t2_second_grant", 32'(grant_id), 32'd1);
    chk("t2_second_ready", 32'(req_ready), 32'b10);
    repeat (14) step();

    // Fairness: both continuously valid, six frames alternate 0,1,0,1,...
    busy_len = 3;
    do_reset(2);
    refill = 1;
    req_data = 16'hB0A0; req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      step();
      if (tx_start === 1'b1) begin
        chk("t3_grant", 32'(grant_id), 32'(n % 2));
        chk("t3_data", 32'(tx_data), (n % 2 == 1) ? 32'(8'hB0 + n / 2) : 32'(8'hA0 + n / 2));
        n++;
      end
    end
    chk("t3_frames", 32'(n), 32'd6);

    // Timeout: busy never rises; pulse at S+17, pending request restarts at S+18
    busy_mode = 0; tx_busy = 1'b0;
    do_reset(2);
    req_valid = 2'b11; req_data = 16'h3C5A;
    step();
    chk("t4_start", 32'(tx_start), 32'd1);
    chk("t4_data", 32'(tx_data), 32'h5A);
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("t4_timeout", 32'(timeout_err), 32'(k == 17));
      chk("t4_restart", 32'(tx_start), 32'(k == 18));
      if (k == 17) chk("t4_arb_idle", 32'(arb_busy), 32'd0);
    end
    chk("t4_regrant", 32'(grant_id), 32'd1);
    chk("t4_redata", 32'(tx_data), 32'h3C);
    chk("t4_reready", 32'(req_ready), 32'b10);

    // Idle blocking: busy high while idle; last busy cycle U, start at U+2
    tx_busy = 1'b1;
    do_reset(2);
    req_valid = 2'b01; req_data = 16'h00C3;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t5_blocked", 32'(tx_start), 32'd0);
      chk("t5_arb", 32'(arb_busy), 32'd0);
    end
    step();
    tx_busy = 1'b0;
    chk("t5_u1", 32'(tx_start), 32'd0);
    step();
    chk("t5_u2", 32'(tx_start), 32'd1);
    chk("t5_data", 32'(tx_data), 32'hC3);

    // Reset in WAIT_DONE with requester 1 last granted; requester 0 wins after
    busy_mode = 1; busy_len = 10;
    do_reset(2);
    req_valid = 2'b10; req_data = 16'h6655;
    step();
    s = cyc;
    chk("t6_grant1", 32'(grant_id), 32'd1);
    req_valid = 2'b11; req_data = 16'h6755;
    repeat (3) step();
    chk("t6_wait_done", 32'(arb_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_start", 32'(tx_start), 32'd0);
    chk("t6_rst_data", 32'(tx_data), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_grant", 32'(grant_id), 32'd0);
    chk("t6_rst_arb", 32'(arb_busy), 32'd0);
    chk("t6_rst_timeout", 32'(timeout_err), 32'd0);
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      step();
      if (tx_start === 1'b1) found = 1;
    end
    chk("t6_found", 32'(found), 32'd1);
    chk("t6_start_cycle", 32'(cyc - s), 32'd12);
    chk("t6_grant0", 32'(grant_id), 32'd0);
    chk("t6_data0", 32'(tx_data), 32'h55);

    // Randomized traffic against a cycle-level reference of the sharing rules
    busy_mode = 1; busy_rand = 1; tx_busy = 1'b0;
    do_reset(2);
    refill    = 2;
    req_valid = N'($urandom);
    req_data  = 16'($urandom);
    idle_from = cyc;
    exp_to    = -1;
    exp_last  = N - 1;
    exp_data  = 8'h00;
    exp_grant = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      step();
      exp_start = (cyc - 1 >= idle_from) && (v_prev != '0) && !b_prev;
      exp_ready = '0;
      if (exp_start) begin
        w = exp_last;
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (found == 0 && v_prev[(exp_last + k) % N]) begin
            w = (exp_last + k) % N;
            found = 1;
          end
        end
        exp_last  = w;
        exp_grant = 1'(w);
        exp_data  = d_prev[8*w +: 8];
        exp_ready = N'(1) << w;
        if (cur_len == 0) begin
          idle_from = cyc + TO + 1;
          exp_to    = cyc + TO + 1;
        end else begin
          idle_from = cyc + cur_len + 2;
        end
      end
      chk("rnd_start", 32'(tx_start), 32'(exp_start));
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      chk("rnd_grant", 32'(grant_id), 32'(exp_grant));
      chk("rnd_data", 32'(tx_data), 32'(exp_data));
      chk("rnd_timeout", 32'(timeout_err), 32'(cyc == exp_to));
      chk("rnd_arb", 32'(arb_busy), 32'(!(cyc >= idle_from)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter (UART_TX: TX_Start / TX_DATA / TX_BUSY) among NUM_REQ byte sources, e.g. CPU MMIO store path and debug/echo path. Round-robin grant, valid/ready handshake toward requesters, and one-byte-at-a-time sequencing of the transmitter. It watches TX_BUSY and has a watchdog for a transmitter that never goes busy. Sits between the requesters and UART_TX inside the UART peripheral, on clk_100MHz.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BUSY_TIMEOUT, 16, WAIT_BUSY cycles allowed before TX_BUSY must rise (>=2)

Ports:
clk_100MHz  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
req_valid  input  NUM_REQ  requester i has a byte pending; held until its req_ready pulse
req_data  input  8*NUM_REQ  requester i byte at [8i+7:8i]
req_ready  output  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i consumed
TX_BUSY  input  1  from UART_TX, high while a frame is shifting
TX_Start  output  1  to UART_TX, 1-cycle start pulse
TX_DATA  output  8  to UART_TX, byte being sent, stable from TX_Start until next grant
grant_id  output  $clog2(NUM_REQ) (min 1)  index of last granted requester
arb_busy  output  1  high whenever state != IDLE
timeout_err  output  1  1-cycle pulse: TX_BUSY never rose

Behaviour:
- Reset (any state): state=IDLE. TX_Start=0, TX_DATA=0, req_ready=0, grant_id=0, arb_busy=0, timeout_err=0. Timer=0. RR pointer last=NUM_REQ-1, so requester 0 has first priority.
- All outputs registered. FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: grant only if TX_BUSY=0 and |req_valid. The winner is the first valid index scanning last+1, last+2, … mod NUM_REQ. On grant:
  - TX_DATA<=req_data[winner], grant_id<=winner, last<=winner, go START.
  - If TX_BUSY=1 in IDLE, no grant (shared line busy).
- START (1 cycle): TX_Start=1, req_ready[grant_id]=1, timer<=0, go WAIT_BUSY.
  - Latency: grant decided in cycle T; TX_Start and req_ready at T+1.
- WAIT_BUSY: if TX_BUSY=1, go WAIT_DONE. Otherwise timer++.
  - If TX_BUSY=0 on the BUSY_TIMEOUT-th WAIT_BUSY cycle: next cycle timeout_err=1 and state=IDLE.
  - Timeout pulse appears at S+BUSY_TIMEOUT+1, where S is the TX_Start cycle.
  - The byte is considered consumed; no retry.
- WAIT_DONE: stay while TX_BUSY=1. On TX_BUSY=0, go IDLE.
  - Earliest next TX_Start is 2 cycles after the cycle TX_BUSY is first seen low.
- Requester deasserting req_valid before being granted: simply not granted, no error.
- Requester may present its next byte the cycle after its req_ready pulse. It competes normally in the next IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. Each requester gets at most one byte per NUM_REQ frames.
- Reset asserted mid-frame: FSM aborts immediately to the reset state. The UART_TX frame in flight is not this block's concern. An in-progress requester keeps its byte if req_ready had not yet pulsed.
- req_ready and TX_Start are never asserted in the same cycle as timeout_err.

Decomposition:
- Package uart_ctrl_pkg:
  - state enum {IDLE, START, WAIT_BUSY, WAIT_DONE}
  - UART_BYTE_W=8
  - helper function for grant index width (clog2, min 1)
- Sub-module uart_rr_pick: combinational round-robin picker. Inputs req_valid and last; outputs winner index and any_valid. Reused later for RX-side consumers.
- Timer and FSM stay in uart_tx_arbiter.

Test Plan:
- Single request, TX_BUSY model rises 1 cycle after start and falls 10 cycles later. req_valid=01, data0=0x41 at T. Required response:
  - T+1: TX_Start=1, TX_DATA=0x41, req_ready=01, grant_id=0.
  - arb_busy falls the cycle after TX_BUSY falls.
- Simultaneous requests right after reset, data0=0x11, data1=0x22, both valid at T. Required response:
  - 0x11 is sent first, then 0x22.
  - Second TX_Start comes exactly 2 cycles after TX_BUSY first reads 0.
- Fairness: requester 0 always valid (0xA0…), requester 1 always valid (0xB0…), 6 frames -> grant_id sequence 0,1,0,1,0,1.
- Timeout: TX_BUSY tied 0, BUSY_TIMEOUT=16, TX_Start at S. Required response:
  - timeout_err=1 only at S+17, with state IDLE.
  - Pending request re-granted at S+17, TX_Start at S+18.
- Idle blocking: TX_BUSY=1 while in IDLE with req_valid=01 -> no TX_Start. When TX_BUSY drops at cycle U, TX_Start at U+2.
- Reset in WAIT_DONE (TX_BUSY=1), requester 1 last granted, both valid. Next cycle all outputs 0. After release, requester 0 is granted first.
